// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
//   master : upstream/downstream side (drives ID/EX bundle, stall, flush;
//            receives stall_req and the registered sal_* EX/MEM outputs)
//   slave  : the execute stage itself
// Signals:
//   stall, flush                  pipeline control from the hazard unit
//   RegDst..RegWrite, AluOP       ID/EX control bits
//   data1, data2, sign_ex, add_pc ID/EX datapath values
//   rt_field, rd_field, funct     instruction fields
//   stall_req                     combinational freeze request (multiply)
//   sal_*                         registered EX/MEM contents
interface ex_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             flush;
  logic             RegDst, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite;
  logic [2:0]       AluOP;
  logic [WIDTH-1:0] data1, data2, sign_ex, add_pc;
  logic [4:0]       rt_field, rd_field;
  logic [5:0]       funct;
  logic             stall_req;
  logic             sal_RegWrite, sal_MemtoReg, sal_MemWrite, sal_MemRead, sal_Branch;
  logic             sal_zero;
  logic [WIDTH-1:0] sal_alu_result, sal_data2, sal_branch_target;
  logic [4:0]       sal_write_reg;

  modport master (
    output stall, flush, RegDst, ALUSrc, Branch, MemRead, MemWrite, MemtoReg,
           RegWrite, AluOP, data1, data2, sign_ex, add_pc, rt_field, rd_field, funct,
    input  stall_req, sal_RegWrite, sal_MemtoReg, sal_MemWrite, sal_MemRead,
           sal_Branch, sal_zero, sal_alu_result, sal_data2, sal_branch_target,
           sal_write_reg
  );

  modport slave (
    input  stall, flush, RegDst, ALUSrc, Branch, MemRead, MemWrite, MemtoReg,
           RegWrite, AluOP, data1, data2, sign_ex, add_pc, rt_field, rd_field, funct,
    output stall_req, sal_RegWrite, sal_MemtoReg, sal_MemWrite, sal_MemRead,
           sal_Branch, sal_zero, sal_alu_result, sal_data2, sal_branch_target,
           sal_write_reg
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage. ALU control decode, operand select, ALU,
// branch-target add, destination-register select, and the EX/MEM register
// with stall/flush handling.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  ex_stage_if.slave (ID/EX bundle in, stall/flush in,
//        stall_req and registered sal_* outputs out)
// Build option: define EX_MULT_EN to compile in the iterative shift-add
// multiplier (funct 011000) and its IDLE/MUL FSM. Without it, mult is an
// unknown funct (result 0) and stall_req is tied low.
module ex_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);

  logic [WIDTH-1:0] op_a, op_b, alu_res, br_tgt;
  logic [4:0]       wr_sel;
  logic [4:0]       ctrl_live;  // {RegWrite, MemtoReg, MemWrite, MemRead, Branch}
  logic             slt_res;

  logic [4:0]       ctrl_q, ctrl_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] res_q, res_d, data2_q, data2_d, bt_q, bt_d;
  logic [4:0]       wr_q, wr_d;

  logic             do_load, do_bubble, stall_req;
  logic [WIDTH-1:0] fin_res;
  logic [4:0]       fin_ctrl, fin_wr;

  assign op_a      = bus.data1;
  assign op_b      = bus.ALUSrc ? bus.sign_ex : bus.data2;
  assign slt_res   = $signed(op_a) < $signed(op_b);
  assign br_tgt    = bus.add_pc + (bus.sign_ex << 2);
  assign wr_sel    = bus.RegDst ? bus.rd_field : bus.rt_field;
  assign ctrl_live = {bus.RegWrite, bus.MemtoReg, bus.MemWrite, bus.MemRead, bus.Branch};

  always_comb begin
    alu_res = '0;
    case (bus.AluOP)
      3'b000, 3'b111: alu_res = op_a + op_b;
      3'b001:         alu_res = op_a - op_b;
      3'b010: begin
        case (bus.funct)
          6'b100000: alu_res = op_a + op_b;
          6'b100010: alu_res = op_a - op_b;
          6'b100100: alu_res = op_a & op_b;
          6'b100101: alu_res = op_a | op_b;
          6'b100111: alu_res = ~(op_a | op_b);
          6'b101010: alu_res = {{(WIDTH-1){1'b0}}, slt_res};
          default:   alu_res = '0;
        endcase
      end
      3'b011:         alu_res = op_a & op_b;
      3'b100:         alu_res = op_a | op_b;
      3'b101:         alu_res = {{(WIDTH-1){1'b0}}, slt_res};
      3'b110:         alu_res = op_b << 16;
      default:        alu_res = '0;
    endcase
  end

`ifdef EX_MULT_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_step;
  logic [4:0]       hctrl_q, hctrl_d, hwr_q, hwr_d;
  logic             is_mult;

  assign is_mult  = (bus.AluOP == 3'b010) && (bus.funct == 6'b011000);
  // Step result including the current multiplier bit; at cnt 31 this is
  // the complete low-word product, so the capture edge uses it directly.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hctrl_q  <= '0;
      hwr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      hctrl_q  <= hctrl_d;
      hwr_q    <= hwr_d;
    end
  end
`endif

  always_comb begin
    do_load   = 1'b0;
    do_bubble = 1'b0;
    stall_req = 1'b0;
    fin_res   = alu_res;
    fin_ctrl  = ctrl_live;
    fin_wr    = wr_sel;
`ifdef EX_MULT_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    hctrl_d  = hctrl_q;
    hwr_d    = hwr_q;

    case (state_q)
      S_IDLE: stall_req = is_mult && !bus.flush && !rst;
      S_MUL:  stall_req = (cnt_q != 5'd31) && !rst;
    endcase

    if (bus.flush) begin
      do_bubble = 1'b1;
      state_d   = S_IDLE;
      cnt_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_mult) begin
            if (!bus.stall) begin
              state_d   = S_MUL;
              mcand_d   = bus.data1;
              mplier_d  = bus.data2;
              acc_d     = '0;
              cnt_d     = '0;
              hctrl_d   = ctrl_live;
              hwr_d     = wr_sel;
              do_bubble = 1'b1;
            end
          end else if (!bus.stall) begin
            do_load = 1'b1;
          end
        end
        S_MUL: begin
          // Stepping continues under stall; only the final capture waits.
          if (cnt_q != 5'd31) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
          end else if (!bus.stall) begin
            fin_res  = acc_step;
            fin_ctrl = hctrl_q;
            fin_wr   = hwr_q;
            do_load  = 1'b1;
            state_d  = S_IDLE;
          end
        end
      endcase
    end
`else
    if (bus.flush) begin
      do_bubble = 1'b1;
    end else if (!bus.stall) begin
      do_load = 1'b1;
    end
`endif

    ctrl_d  = ctrl_q;
    zero_d  = zero_q;
    res_d   = res_q;
    data2_d = data2_q;
    bt_d    = bt_q;
    wr_d    = wr_q;
    if (do_bubble) begin
      ctrl_d = '0;
      zero_d = 1'b0;
    end else if (do_load) begin
      ctrl_d  = fin_ctrl;
      res_d   = fin_res;
      zero_d  = (fin_res == '0);
      data2_d = bus.data2;
      bt_d    = br_tgt;
      wr_d    = fin_wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      zero_q  <= 1'b0;
      res_q   <= '0;
      data2_q <= '0;
      bt_q    <= '0;
      wr_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      zero_q  <= zero_d;
      res_q   <= res_d;
      data2_q <= data2_d;
      bt_q    <= bt_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.stall_req         = stall_req;
  assign bus.sal_RegWrite      = ctrl_q[4];
  assign bus.sal_MemtoReg      = ctrl_q[3];
  assign bus.sal_MemWrite      = ctrl_q[2];
  assign bus.sal_MemRead       = ctrl_q[1];
  assign bus.sal_Branch        = ctrl_q[0];
  assign bus.sal_zero          = zero_q;
  assign bus.sal_alu_result    = res_q;
  assign bus.sal_data2         = data2_q;
  assign bus.sal_branch_target = bt_q;
  assign bus.sal_write_reg     = wr_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage. Expected EX/MEM contents are
// pushed when a bundle is driven and popped/compared one edge later.
// Multiply scenarios are compiled when EX_MULT_EN is defined.
module tb_ex_stage;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  ex_stage_if #(.WIDTH(32)) bus ();
  ex_stage #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic        zero;
    logic [31:0] res;
    logic [31:0] d2;
    logic [31:0] bt;
    logic [4:0]  wr;
  } exp_t;

  exp_t sb[$];
  exp_t last;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_ex();
    exp_t e;
    logic [31:0] a, b, r;
    a = bus.data1;
    b = bus.ALUSrc ? bus.sign_ex : bus.data2;
    r = 32'd0;
    case (bus.AluOP)
      3'd0, 3'd7: r = a + b;
      3'd1:       r = a - b;
      3'd3:       r = a & b;
      3'd4:       r = a | b;
      3'd5:       r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:       r = {b[15:0], 16'h0000};
      default: begin
        case (bus.funct)
          6'h20:   r = a + b;
          6'h22:   r = a - b;
          6'h24:   r = a & b;
          6'h25:   r = a | b;
          6'h27:   r = ~(a | b);
          6'h2a:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: r = 32'd0;
        endcase
      end
    endcase
    e.ctrl = {bus.RegWrite, bus.MemtoReg, bus.MemWrite, bus.MemRead, bus.Branch};
    e.res  = r;
    e.zero = (r == 32'd0);
    e.d2   = bus.data2;
    e.bt   = bus.add_pc + {bus.sign_ex[29:0], 2'b00};
    e.wr   = bus.RegDst ? bus.rd_field : bus.rt_field;
    return e;
  endfunction

  task automatic push_expected();
    last = model_ex();
    sb.push_back(last);
  endtask

  task automatic push_hold();
    sb.push_back(last);
  endtask

  task automatic push_bubble();
    last.ctrl = '0;
    last.zero = 1'b0;
    sb.push_back(last);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    check_val({tag, " queue"}, 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check_val({tag, " ctrl"}, {27'd0, bus.sal_RegWrite, bus.sal_MemtoReg, bus.sal_MemWrite,
              bus.sal_MemRead, bus.sal_Branch}, {27'd0, e.ctrl});
    check_val({tag, " zero"}, {31'd0, bus.sal_zero}, {31'd0, e.zero});
    check_val({tag, " result"}, bus.sal_alu_result, e.res);
    check_val({tag, " data2"}, bus.sal_data2, e.d2);
    check_val({tag, " target"}, bus.sal_branch_target, e.bt);
    check_val({tag, " wreg"}, {27'd0, bus.sal_write_reg}, {27'd0, e.wr});
  endtask

  task automatic step_check(input string tag);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic set_ops(input logic [2:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic alusrc);
    bus.AluOP    = op;
    bus.funct    = fn;
    bus.data1    = a;
    bus.data2    = b;
    bus.sign_ex  = imm;
    bus.ALUSrc   = alusrc;
    bus.RegDst   = 1'($urandom_range(0, 1));
    bus.Branch   = 1'($urandom_range(0, 1));
    bus.MemRead  = 1'($urandom_range(0, 1));
    bus.MemWrite = 1'($urandom_range(0, 1));
    bus.MemtoReg = 1'($urandom_range(0, 1));
    bus.RegWrite = 1'b1;
    bus.rt_field = 5'($urandom);
    bus.rd_field = 5'($urandom);
    bus.add_pc   = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic run_vec(input string tag, input logic [2:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic alusrc);
    set_ops(op, fn, a, b, imm, alusrc);
    push_expected();
    step_check(tag);
  endtask

`ifdef EX_MULT_EN
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic [31:0] prod,
                          input bit hold_end);
    exp_t em;
    int   cycles;
    set_ops(3'd2, 6'h18, a, b, 32'h10, 1'b0);
    bus.RegDst   = 1'b1;
    bus.rd_field = 5'd10;
    em.ctrl = {bus.RegWrite, bus.MemtoReg, bus.MemWrite, bus.MemRead, bus.Branch};
    em.res  = prod;
    em.zero = (prod == 32'd0);
    em.d2   = b;
    em.bt   = bus.add_pc + 32'h40;
    em.wr   = 5'd10;
    check_val("mult stall_req start", {31'd0, bus.stall_req}, 32'd1);
    push_bubble();
    cycles = 0;
    while (bus.stall_req === 1'b1 && cycles < 40) begin
      cycles++;
      @(posedge clk);
      #1;
      if (cycles == 1) compare_out("mult bubble");
    end
    check_val("mult stall cycles", 32'(cycles), 32'd32);
    if (hold_end) begin
      bus.stall = 1'b1;
      repeat (2) begin
        push_hold();
        step_check("mult hold31");
        check_val("mult hold31 stall_req", {31'd0, bus.stall_req}, 32'd0);
      end
      bus.stall = 1'b0;
    end
    sb.push_back(em);
    last = em;
    step_check("mult result");
    check_val("mult value", bus.sal_alu_result, prod);
    set_ops(3'd0, 6'h20, 32'd1, 32'd1, 32'd0, 1'b0);
  endtask
`endif

  initial begin
    rst       = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_ops(3'd0, 6'h00, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    last = '0;
    sb.push_back(last);
    compare_out("reset");
    check_val("reset stall_req", {31'd0, bus.stall_req}, 32'd0);
    rst = 1'b0;

    // R-type add example
    set_ops(3'd2, 6'h20, 32'd5, 32'd7, 32'd0, 1'b0);
    bus.RegDst = 1'b1; bus.rd_field = 5'd9; bus.RegWrite = 1'b1;
    push_expected();
    step_check("radd");
    check_val("radd value", bus.sal_alu_result, 32'd12);
    check_val("radd wreg", {27'd0, bus.sal_write_reg}, 32'd9);
    check_val("radd zero", {31'd0, bus.sal_zero}, 32'd0);

    // beq example
    set_ops(3'd1, 6'h00, 32'd3, 32'd3, 32'd4, 1'b0);
    bus.Branch = 1'b1; bus.add_pc = 32'h100;
    push_expected();
    step_check("beq");
    check_val("beq zero", {31'd0, bus.sal_zero}, 32'd1);
    check_val("beq target", bus.sal_branch_target, 32'h110);
    check_val("beq branch", {31'd0, bus.sal_Branch}, 32'd1);

    run_vec("sub",      3'd1, 6'h00, 32'd10, 32'd3, 32'd0, 1'b0);
    run_vec("and",      3'd3, 6'h00, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 1'b0);
    run_vec("or",       3'd4, 6'h00, 32'hF000_0001, 32'h0000_1000, 32'd0, 1'b0);
    run_vec("slt neg",  3'd5, 6'h00, 32'hFFFF_FFFB, 32'd3, 32'd0, 1'b0);
    run_vec("slt pos",  3'd5, 6'h00, 32'd3, 32'hFFFF_FFFB, 32'd0, 1'b0);
    run_vec("lui",      3'd6, 6'h00, 32'hDEAD_BEEF, 32'd0, 32'h0000_1234, 1'b1);
    run_vec("addi wrap",3'd7, 6'h00, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1);
    run_vec("r sub",    3'd2, 6'h22, 32'd4, 32'd9, 32'd0, 1'b0);
    run_vec("r and",    3'd2, 6'h24, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 1'b0);
    run_vec("r or",     3'd2, 6'h25, 32'h0000_00F0, 32'h0F00_0000, 32'd0, 1'b0);
    run_vec("r nor",    3'd2, 6'h27, 32'h0000_FFFF, 32'hFF00_0000, 32'd0, 1'b0);
    run_vec("r slt",    3'd2, 6'h2a, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0);
    run_vec("r unknown",3'd2, 6'h3f, 32'd11, 32'd22, 32'd0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [2:0] op;
      logic [5:0] fn;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        3: fn = 6'h25;
        4: fn = 6'h27;
        default: fn = 6'h2a;
      endcase
      run_vec("random", op, fn, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

`ifndef EX_MULT_EN
    set_ops(3'd2, 6'h18, 32'd7, 32'd6, 32'd0, 1'b0);
    check_val("nomult stall_req", {31'd0, bus.stall_req}, 32'd0);
    push_expected();
    step_check("nomult");
    check_val("nomult value", bus.sal_alu_result, 32'd0);
`endif

    // stall for three cycles, then flush with stall still high
    run_vec("pre-stall", 3'd0, 6'h00, 32'd100, 32'd23, 32'd0, 1'b0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ops(3'd4, 6'h00, $urandom, $urandom, $urandom, 1'b0);
      push_hold();
      step_check("stall hold");
    end
    bus.flush = 1'b1;
    push_bubble();
    step_check("flush over stall");
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // asynchronous reset mid-cycle
    run_vec("pre-rst", 3'd0, 6'h00, 32'd1, 32'd2, 32'd0, 1'b0);
    #3 rst = 1'b1;
    #1;
    last = '0;
    sb.push_back(last);
    compare_out("async rst");
    check_val("async rst stall_req", {31'd0, bus.stall_req}, 32'd0);
    #1 rst = 1'b0;
    run_vec("post-rst", 3'd3, 6'h00, 32'hFF, 32'h0F, 32'd0, 1'b0);

`ifdef EX_MULT_EN
    run_mult(32'd7, 32'd6, 32'd42, 1'b0);
    run_vec("post mult", 3'd0, 6'h00, 32'd2, 32'd2, 32'd0, 1'b0);
    run_mult(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
    run_vec("post mult2", 3'd1, 6'h00, 32'd9, 32'd2, 32'd0, 1'b0);

    // flush at cnt = 10
    set_ops(3'd2, 6'h18, 32'd9, 32'd9, 32'd0, 1'b0);
    push_bubble();
    step_check("abort bubble0");
    repeat (10) @(posedge clk);
    #1;
    check_val("abort cnt10 stall_req", {31'd0, bus.stall_req}, 32'd1);
    bus.flush = 1'b1;
    set_ops(3'd0, 6'h00, 32'd3, 32'd4, 32'd0, 1'b0);
    push_bubble();
    step_check("abort flush");
    bus.flush = 1'b0;
    check_val("abort stall_req", {31'd0, bus.stall_req}, 32'd0);
    push_expected();
    step_check("after abort");

    // reset at cnt = 10
    set_ops(3'd2, 6'h18, 32'd5, 32'd5, 32'd0, 1'b0);
    push_bubble();
    step_check("rst abort bubble0");
    repeat (10) @(posedge clk);
    #1;
    #3 rst = 1'b1;
    #1;
    last = '0;
    sb.push_back(last);
    compare_out("rst abort");
    check_val("rst abort stall_req", {31'd0, bus.stall_req}, 32'd0);
    set_ops(3'd4, 6'h00, 32'd8, 32'd1, 32'd0, 1'b0);
    #1 rst = 1'b0;
    push_expected();
    step_check("after rst abort");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the MIPS pipeline, sitting directly downstream of the ID/EX buffer. It consumes the ID/EX bundle (control bits, register operands, sign-extended immediate, PC+4, rd/funct fields) and performs ALU control decode, operand select, ALU operation, branch-target add and destination-register select. It registers the results into the EX/MEM pipeline register, with stall and flush handling. An optional iterative multiplier adds a multi-cycle state machine that back-pressures the front end.

## Interface
Parameters:
- WIDTH, 32: datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  hold EX/MEM contents; no state change except the multiplier counter.
- flush  in  1  load a bubble into EX/MEM and abort any multiply.
- RegDst, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  control bits from ID/EX.
- AluOP  in  3  ALU operation class.
- data1, data2  in  32  rs and rt operand values.
- sign_ex  in  32  sign-extended immediate.
- add_pc  in  32  PC+4.
- rt_field  in  5  instruction bits [20:16].
- rd_field  in  5  instruction bits [15:11].
- funct  in  6  instruction bits [5:0].
- stall_req  out  1  combinational; asks the hazard unit to freeze PC, IF/ID and ID/EX.
- sal_RegWrite, sal_MemtoReg, sal_MemWrite, sal_MemRead, sal_Branch  out  1 each  registered control bits.
- sal_zero  out  1  registered; high when the ALU result is 0.
- sal_alu_result  out  32  registered ALU or multiply result.
- sal_data2  out  32  registered store data (data2).
- sal_branch_target  out  32  registered value of add_pc + (sign_ex << 2), modulo 2^32.
- sal_write_reg  out  5  registered; rd_field if RegDst is 1, else rt_field.

## Operation
- Operand B = ALUSrc ? sign_ex : data2.
- AluOP decode:
  - 000 add
  - 001 sub
  - 010 R-type, decoded from funct
  - 011 and
  - 100 or
  - 101 slt
  - 110 lui: result = B << 16
  - 111 add
- funct decode (AluOP 010):
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 100111 nor
  - 101010 slt
  - 011000 mult (see Configuration)
  - any other value: result 0
- Arithmetic is 32-bit wraparound with no overflow trap. slt is a signed compare giving 1 or 0.
- sal_zero is computed from the final value written to sal_alu_result.
- Bubble: all sal_ control bits and sal_zero are 0; data outputs are unchanged.
- Priority each edge: rst > flush > stall > normal load.
- Reset value of every output is 0; FSM goes to IDLE and the multiplier counter is cleared.

## Timing
- Non-multiply instructions: 1-cycle latency. The ID/EX bundle present before edge N appears on the sal_ outputs after edge N.
- stall high: all sal_ outputs hold.
- flush high: bubble loaded at that edge, even if stall is also high.
- Multiply FSM has two states, IDLE and MUL.
  - IDLE with a mult decoded and no flush: stall_req = 1 combinationally. If stall is low, the next edge loads multiplicand and multiplier, clears the accumulator, sets cnt = 0, enters MUL and loads a bubble into EX/MEM. If stall is high, the FSM remains in IDLE.
  - MUL: one shift-add step per edge. stall_req = 1 while cnt < 31.
  - At cnt = 31, stall_req = 0. The next edge captures the low 32 bits of the product plus the held ID/EX controls and write register into EX/MEM, then returns to IDLE. If stall is high at cnt = 31, the FSM stays at cnt = 31 without re-stepping until stall is low.
  - Total: the mult result appears 33 edges after the mult first reaches EX.
- flush in MUL: abort, return to IDLE, bubble, stall_req drops the next cycle.
- rst in MUL: immediate return to IDLE; all outputs 0.

## Configuration
- EX_MULT_EN defined: multiplier, FSM and counter are compiled in, with behaviour as described in Timing.
- EX_MULT_EN undefined: funct 011000 behaves as an unknown funct (result 0, 1-cycle latency). stall_req is tied to 0 and no FSM is built.

## Test plan
- Reset: assert rst mid-cycle -> all outputs 0 immediately, stall_req 0.
- R-type add: data1 = 5, data2 = 7, AluOP = 010, funct = 100000, RegDst = 1, rd_field = 9, RegWrite = 1 -> after one edge, sal_alu_result = 12, sal_write_reg = 9, sal_RegWrite = 1, sal_zero = 0.
- beq: data1 = data2 = 3, AluOP = 001, Branch = 1, add_pc = 0x100, sign_ex = 4 -> sal_zero = 1, sal_branch_target = 0x110, sal_Branch = 1.
- Stall then flush: load an instruction, hold stall for 3 cycles -> outputs unchanged. Then assert flush together with stall -> all control outputs 0.
- Multiply (EX_MULT_EN): data1 = 7, data2 = 6, funct = 011000 -> stall_req high for 32 cycles, sal_alu_result = 42 at edge 33. Also check 0xFFFFFFFF × 2 -> 0xFFFFFFFE.
- Mid-multiply abort: flush at cnt = 10 -> bubble, IDLE, stall_req 0 next cycle. Repeat with rst -> all outputs 0.
